// File: rtl/montgomery_square_sequencer.sv
// Montgomery squaring sequencer: drives one shared multicycle multiply-accumulate unit through
// T=A*A, m=T*N' mod R, U=(T+m*N)/R for a programmable number of squarings. Option: MONT_FINAL_SUB_EN.
module montgomery_square_sequencer #(
   parameter int WIDTH       = 1026,
   parameter int ITER_W      = 64,
   parameter int MULT_CYCLES = 4
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 start,
   input  logic [WIDTH-1:0]     sq_in,
   input  logic [ITER_W-1:0]    iterations,
   input  logic [WIDTH-1:0]     modulus,
   input  logic [WIDTH-1:0]     nprime,
   output logic                 busy,
   output logic                 valid,
   output logic [WIDTH-1:0]     sq_out,
   output logic [WIDTH-1:0]     mul_x,
   output logic [WIDTH-1:0]     mul_y,
   output logic [2*WIDTH-1:0]   mul_accum,
   input  logic [2*WIDTH-1:0]   mul_p
);

   localparam int PH_W = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES) : 1;
   localparam logic [PH_W-1:0]   PH_LAST = PH_W'(MULT_CYCLES - 1);
   localparam logic [PH_W-1:0]   PH_ONE  = PH_W'(1);
   localparam logic [ITER_W-1:0] CNT_ONE = ITER_W'(1);

`ifdef MONT_FINAL_SUB_EN
   typedef enum logic [2:0] {IDLE, SQ, LO, HI, SUB, DONE} state_t;
`else
   typedef enum logic [2:0] {IDLE, SQ, LO, HI, DONE} state_t;
`endif

   state_t              state, state_next;
   logic [PH_W-1:0]     ph;
   logic [ITER_W-1:0]   cnt;
   logic [WIDTH-1:0]    a_reg;
   logic [2*WIDTH-1:0]  t_reg;
   logic [WIDTH-1:0]    m_reg;
`ifdef MONT_FINAL_SUB_EN
   logic [WIDTH-1:0]    u_reg;
`endif
   logic                ph_last;

   assign ph_last = (ph == PH_LAST);
   assign busy    = (state != IDLE);

   always_ff @(posedge clk) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Operands come only from registers and state, so they stay constant across a whole phase.
   always_comb begin
      // NOTE: every output gets a default first so no path through the case infers a latch.
      state_next = state;
      mul_x      = '0;
      mul_y      = '0;
      mul_accum  = '0;
      case (state)
         IDLE: begin
            if (start) state_next = (iterations == '0) ? DONE : SQ;
         end
         SQ: begin
            mul_x = a_reg;
            mul_y = a_reg;
            if (ph_last) state_next = LO;
         end
         LO: begin
            mul_x = t_reg[WIDTH-1:0];
            mul_y = nprime;
            if (ph_last) state_next = HI;
         end
         HI: begin
            mul_x     = m_reg;
            mul_y     = modulus;
            mul_accum = t_reg;
`ifdef MONT_FINAL_SUB_EN
            if (ph_last) state_next = SUB;
`else
            if (ph_last) state_next = (cnt == CNT_ONE) ? DONE : SQ;
`endif
         end
`ifdef MONT_FINAL_SUB_EN
         SUB: begin
            state_next = (cnt == '0) ? DONE : SQ;
         end
`endif
         DONE: begin
            state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   // Datapath registers; the low WIDTH bits of T+m*N are zero by construction and dropped.
   always_ff @(posedge clk) begin
      if (reset) begin
         ph     <= '0;
         cnt    <= '0;
         a_reg  <= '0;
         t_reg  <= '0;
         m_reg  <= '0;
`ifdef MONT_FINAL_SUB_EN
         u_reg  <= '0;
`endif
         sq_out <= '0;
         valid  <= 1'b0;
      end else begin
         valid <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  a_reg <= sq_in;
                  cnt   <= iterations;
                  ph    <= '0;
               end
            end
            SQ: begin
               ph <= ph_last ? '0 : ph + PH_ONE;
               if (ph_last) t_reg <= mul_p;
            end
            LO: begin
               ph <= ph_last ? '0 : ph + PH_ONE;
               if (ph_last) m_reg <= mul_p[WIDTH-1:0];
            end
            HI: begin
               ph <= ph_last ? '0 : ph + PH_ONE;
               if (ph_last) begin
                  cnt <= cnt - CNT_ONE;
`ifdef MONT_FINAL_SUB_EN
                  u_reg <= mul_p[2*WIDTH-1:WIDTH];
`else
                  a_reg <= mul_p[2*WIDTH-1:WIDTH];
`endif
               end
            end
`ifdef MONT_FINAL_SUB_EN
            SUB: begin
               a_reg <= (u_reg >= modulus) ? u_reg - modulus : u_reg;
            end
`endif
            DONE: begin
               sq_out <= a_reg;
               valid  <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_montgomery_square_sequencer.sv
// Scoreboard bench for montgomery_square_sequencer: WIDTH=8, N=13, N'=59, MULT_CYCLES=2,
// behavioural multiply-accumulate model; expected results and valid cycles are hand-computed.
module tb_montgomery_square_sequencer;

   localparam int WIDTH = 8;
   localparam int ITER_W = 64;
   localparam int MC = 2;
`ifdef MONT_FINAL_SUB_EN
   localparam int SUB_EXTRA = 1;
   localparam logic [7:0] RES_23 = 8'd1;
`else
   localparam int SUB_EXTRA = 0;
   localparam logic [7:0] RES_23 = 8'd14;
`endif

   logic                clk = 1'b0;
   logic                reset;
   logic                start;
   logic [WIDTH-1:0]    sq_in;
   logic [ITER_W-1:0]   iterations;
   logic [WIDTH-1:0]    modulus;
   logic [WIDTH-1:0]    nprime;
   logic                busy;
   logic                valid;
   logic [WIDTH-1:0]    sq_out;
   logic [WIDTH-1:0]    mul_x;
   logic [WIDTH-1:0]    mul_y;
   logic [2*WIDTH-1:0]  mul_accum;
   logic [2*WIDTH-1:0]  mul_p;

   typedef struct {
      logic [7:0] res;
      int         cyc;
      string      name;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   cyc = 0;
   bit   watch_zero = 1'b0;

   montgomery_square_sequencer #(
      .WIDTH(WIDTH), .ITER_W(ITER_W), .MULT_CYCLES(MC)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .sq_in(sq_in), .iterations(iterations),
      .modulus(modulus), .nprime(nprime), .busy(busy), .valid(valid), .sq_out(sq_out),
      .mul_x(mul_x), .mul_y(mul_y), .mul_accum(mul_accum), .mul_p(mul_p)
   );

   assign mul_p = {8'd0, mul_x} * {8'd0, mul_y} + mul_accum;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   // Monitor: every valid pulse must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (valid) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_valid: got valid with sq_out=%0d at cycle %0d, required no valid",
                     sq_out, cyc);
         end else begin
            exp_t e;
            e = sb.pop_front();
            check({e.name, "_result"}, 64'(sq_out), 64'(e.res));
            check({e.name, "_cycle"}, 64'(cyc), 64'(e.cyc));
         end
      end
      if (watch_zero) begin
         check("iter0_mul_x", 64'(mul_x), 64'd0);
         check("iter0_mul_y", 64'(mul_y), 64'd0);
         check("iter0_mul_accum", 64'(mul_accum), 64'd0);
      end
   end

   // Called just after a rising edge; the next edge accepts the job.
   task automatic issue(input string name, input logic [7:0] a, input logic [63:0] it,
                        input logic [7:0] res, input bit expect_done, output int acc);
      exp_t e;
      start = 1'b1;
      sq_in = a;
      iterations = it;
      acc = cyc + 1;
      if (expect_done) begin
         e.res  = res;
         e.cyc  = acc + 1 + int'(it) * (3 * MC + SUB_EXTRA);
         e.name = name;
         sb.push_back(e);
      end
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input string name);
      for (int i = 0; i < 100; i++) begin
         @(posedge clk); #1;
         if (sb.size() == 0 && !busy) break;
      end
      check({name, "_drained"}, 64'(sb.size()), 64'd0);
      sb.delete();
   endtask

   initial begin
      int acc;
      int lat2;
      reset = 1'b1;
      start = 1'b0;
      sq_in = '0;
      iterations = '0;
      modulus = 8'd13;
      nprime = 8'd59;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_valid", 64'(valid), 64'd0);
      check("rst_sq_out", 64'(sq_out), 64'd0);
      check("rst_mul_x", 64'(mul_x), 64'd0);
      check("rst_mul_accum", 64'(mul_accum), 64'd0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(posedge clk); #1;

      // 5^2 -> T=25, m=195, U=10; operands checked in each phase
      issue("sq5_it1", 8'd5, 64'd1, 8'd10, 1'b1, acc);
      @(negedge clk);
      check("sq_busy", 64'(busy), 64'd1);
      check("sq_x", 64'(mul_x), 64'd5);
      check("sq_y", 64'(mul_y), 64'd5);
      check("sq_accum", 64'(mul_accum), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("lo_x", 64'(mul_x), 64'd25);
      check("lo_y", 64'(mul_y), 64'd59);
      check("lo_accum", 64'(mul_accum), 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("hi_x", 64'(mul_x), 64'd195);
      check("hi_y", 64'(mul_y), 64'd13);
      check("hi_accum", 64'(mul_accum), 64'd25);
      wait_done("sq5_it1");
      repeat (3) @(posedge clk); #1;
      check("hold_sq_out", 64'(sq_out), 64'd10);
      check("hold_valid", 64'(valid), 64'd0);

      issue("sq5_it2", 8'd5, 64'd2, 8'd1, 1'b1, acc);
      wait_done("sq5_it2");
      issue("sq23_it1", 8'd23, 64'd1, RES_23, 1'b1, acc);
      wait_done("sq23_it1");
      issue("sq5_it3", 8'd5, 64'd3, 8'd3, 1'b1, acc);
      wait_done("sq5_it3");

      watch_zero = 1'b1;
      issue("iter0", 8'd7, 64'd0, 8'd7, 1'b1, acc);
      wait_done("iter0");
      watch_zero = 1'b0;

      // start pulsed mid-job and again on the DONE cycle: both ignored
      lat2 = 1 + 2 * (3 * MC + SUB_EXTRA);
      issue("ignore", 8'd5, 64'd2, 8'd1, 1'b1, acc);
      repeat (3) @(posedge clk); #1;
      start = 1'b1; sq_in = 8'd23; iterations = 64'd1;
      @(posedge clk); #1;
      start = 1'b0;
      while (cyc < acc + lat2 - 1) begin
         @(posedge clk); #1;
      end
      start = 1'b1; sq_in = 8'd99; iterations = 64'd0;
      @(posedge clk); #1;
      start = 1'b0;
      check("done_start_busy", 64'(busy), 64'd0);
      wait_done("ignore");
      repeat (4) @(posedge clk); #1;
      check("ignore_idle", 64'(busy), 64'd0);

      // reset during LO aborts the job without a valid and clears sq_out
      issue("abort", 8'd5, 64'd1, 8'd10, 1'b0, acc);
      repeat (2) @(posedge clk); #1;
      check("abort_in_job", 64'(busy), 64'd1);
      reset = 1'b1;
      @(posedge clk); #1;
      check("abort_busy", 64'(busy), 64'd0);
      check("abort_sq_out", 64'(sq_out), 64'd0);
      check("abort_valid", 64'(valid), 64'd0);
      reset = 1'b0;
      repeat (12) @(posedge clk); #1;
      check("abort_sq_out_held", 64'(sq_out), 64'd0);
      issue("after_abort", 8'd23, 64'd1, RES_23, 1'b1, acc);
      wait_done("after_abort");
      repeat (3) @(posedge clk);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
